// File: rtl/register_file_pkg.sv
// Shared definitions for the sweep-cleared register file: controller state
// encoding and the default geometry.
package register_file_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } sweep_state_e;

endpackage

// File: rtl/sweep_ctrl.sv
// Clear-sweep controller: walks the address space one entry per cycle after
// reset or a clear request, and flags writes that arrive while it is busy.
module sweep_ctrl
    import register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write_req,
    output logic                  busy,
    output logic                  write_drop,
    output logic [ADDR_WIDTH-1:0] sweep_addr,
    output sweep_state_e          state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    // busy is kept as its own flop so it is a clean registered output that
    // always tracks state == SWEEP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= SWEEP;
            sweep_addr <= '0;
            busy       <= 1'b1;
            write_drop <= 1'b0;
        end else begin
            case (state)
                SWEEP: begin
                    write_drop <= write_req;
                    if (clear) begin
                        sweep_addr <= '0;
                    end else if (sweep_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        sweep_addr <= '0;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                IDLE: begin
                    // A clear in the same cycle as a write wins; the write is dropped.
                    write_drop <= write_req && clear;
                    if (clear) begin
                        state      <= SWEEP;
                        busy       <= 1'b1;
                        sweep_addr <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/register_file_sweep.sv
// Two-read, one-write register file with optional write-to-read forwarding,
// an optional hard-wired zero register, and a multi-cycle clear sweep.
module register_file_sweep
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Reg_Write_i,
    input  logic [ADDR_WIDTH-1:0] Write_Register_i,
    input  logic [DATA_WIDTH-1:0] Write_Data_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
    output logic [DATA_WIDTH-1:0] Read_Data_1_o,
    output logic [DATA_WIDTH-1:0] Read_Data_2_o,
    input  logic                  Clear_i,
    output logic                  Busy_o,
    output logic                  Write_Drop_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    sweep_state_e          state;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  sweep_en;
    logic                  write_fire;
    logic                  read_blocked;
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    sweep_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sweep_ctrl (
        .clk        (clk),
        .reset      (reset),
        .clear      (Clear_i),
        .write_req  (Reg_Write_i),
        .busy       (Busy_o),
        .write_drop (Write_Drop_o),
        .sweep_addr (sweep_addr),
        .state      (state)
    );

    assign sweep_en     = (state == SWEEP);
    assign read_blocked = !reset || Busy_o;
    assign write_fire   = Reg_Write_i && !Busy_o && !Clear_i
                          && !(ZERO_REG != 0 && Write_Register_i == '0);

    // No reset on the array itself: contents are cleared only by the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (sweep_en) begin
                regs[sweep_addr] <= '0;
            end else if (write_fire) begin
                regs[Write_Register_i] <= Write_Data_i;
            end
        end
    end

    assign rd_addr[0] = Read_Register_1_i;
    assign rd_addr[1] = Read_Register_2_i;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            if (read_blocked || (ZERO_REG != 0 && rd_addr[p] == '0)) begin
                rd_data[p] = '0;
            end else if (BYPASS != 0 && write_fire && rd_addr[p] == Write_Register_i) begin
                rd_data[p] = Write_Data_i;
            end
        end
    end

    assign Read_Data_1_o = rd_data[0];
    assign Read_Data_2_o = rd_data[1];

endmodule

// File: tb/tb_register_file_sweep.sv
// Bench for register_file_sweep: default, no-forwarding and small/no-zero-reg
// builds checked against an array-based reference model.
module tb_register_file_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default (A) and no-bypass (B) builds
    logic        rst_n, clr, wr;
    logic [4:0]  waddr, ra1, ra2;
    logic [31:0] wdata;
    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy, a_drop, b_busy, b_drop;

    // Small build (C): 16-bit data, 8 entries, register 0 is ordinary
    logic        c_rst, c_clr, c_wr;
    logic [2:0]  c_waddr, c_ra1, c_ra2;
    logic [15:0] c_wdata, c_rd1, c_rd2;
    logic        c_busy, c_drop;

    int n_cmp = 0;
    int n_err = 0;

    register_file_sweep #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(rst_n), .Reg_Write_i(wr), .Write_Register_i(waddr),
        .Write_Data_i(wdata), .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
        .Read_Data_1_o(a_rd1), .Read_Data_2_o(a_rd2), .Clear_i(clr),
        .Busy_o(a_busy), .Write_Drop_o(a_drop)
    );

    register_file_sweep #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(rst_n), .Reg_Write_i(wr), .Write_Register_i(waddr),
        .Write_Data_i(wdata), .Read_Register_1_i(ra1), .Read_Register_2_i(ra2),
        .Read_Data_1_o(b_rd1), .Read_Data_2_o(b_rd2), .Clear_i(clr),
        .Busy_o(b_busy), .Write_Drop_o(b_drop)
    );

    register_file_sweep #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset(c_rst), .Reg_Write_i(c_wr), .Write_Register_i(c_waddr),
        .Write_Data_i(c_wdata), .Read_Register_1_i(c_ra1), .Read_Register_2_i(c_ra2),
        .Read_Data_1_o(c_rd1), .Read_Data_2_o(c_rd2), .Clear_i(c_clr),
        .Busy_o(c_busy), .Write_Drop_o(c_drop)
    );

    // Reference model: index 0 tracks A/B, index 1 tracks C. A sweep is
    // modelled as "everything reads zero until sweep_left cycles elapse, then
    // the whole array is zero", so the array is zeroed when the sweep begins.
    logic [31:0] m_mem [2][32];
    bit          m_busy [2];
    int          m_left [2];
    bit          m_drop [2];

    task automatic model_step(input int id, input int depth, input bit zr, input bit rst,
                              input bit c, input bit we, input int wa, input logic [31:0] wd);
        if (!rst) begin
            m_left[id] = depth;
            m_busy[id] = 1'b1;
            m_drop[id] = 1'b0;
            for (int i = 0; i < 32; i++) m_mem[id][i] = '0;
        end else if (m_busy[id]) begin
            m_drop[id] = we;
            m_left[id] = c ? depth : m_left[id] - 1;
            m_busy[id] = (m_left[id] > 0);
        end else if (c) begin
            m_drop[id] = we;
            m_left[id] = depth;
            m_busy[id] = 1'b1;
            for (int i = 0; i < 32; i++) m_mem[id][i] = '0;
        end else begin
            m_drop[id] = 1'b0;
            if (we && !(zr && wa == 0)) m_mem[id][wa] = wd;
        end
    endtask

    function automatic logic [31:0] exp_rd(input int id, input bit byp, input bit zr, input bit rst,
                                           input bit c, input bit we, input int wa,
                                           input logic [31:0] wd, input int ra);
        if (!rst || m_busy[id]) return '0;
        if (zr && ra == 0) return '0;
        if (byp && we && !c && ra == wa) return wd;
        return m_mem[id][ra];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(0, 32, 1'b1, rst_n, clr, wr, int'(waddr), wdata);
        model_step(1, 8, 1'b0, c_rst, c_clr, c_wr, int'(c_waddr), {16'h0, c_wdata});
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((a_busy || c_busy) && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (a_busy !== 1'b0 || c_busy !== 1'b0) begin
            n_err++;
            $display("FAIL wait_idle timeout: busy a=%b c=%b required 0", a_busy, c_busy);
        end
    endtask

    task automatic test_reset();
        int cnt_a = 0, cnt_b = 0, cnt_c = 0;
        rst_n = 1'b0; c_rst = 1'b0; wr = 1'b1; waddr = 5'd3; wdata = 32'h55;
        tick();
        tick();
        ra1 = 5'd3;
        #1;
        n_cmp++;
        if (a_busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b required 1", a_busy); end
        n_cmp++;
        if (a_drop !== 1'b0) begin n_err++; $display("FAIL reset_no_drop: got %b required 0", a_drop); end
        n_cmp++;
        if (a_rd1 !== 32'h0) begin n_err++; $display("FAIL reset_read: got %h required 0", a_rd1); end
        wr = 1'b0;
        rst_n = 1'b1; c_rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (a_busy) cnt_a++;
            if (b_busy) cnt_b++;
            if (c_busy) cnt_c++;
            tick();
        end
        n_cmp++;
        if (cnt_a !== 32) begin n_err++; $display("FAIL sweep_len_a: got %0d required 32", cnt_a); end
        n_cmp++;
        if (cnt_b !== 32) begin n_err++; $display("FAIL sweep_len_b: got %0d required 32", cnt_b); end
        n_cmp++;
        if (cnt_c !== 8) begin n_err++; $display("FAIL sweep_len_c: got %0d required 8", cnt_c); end
        ra1 = 5'd2; ra2 = 5'd31;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0) begin
            n_err++; $display("FAIL post_sweep_read: got %h/%h required 0/0", a_rd1, a_rd2);
        end
    endtask

    task automatic test_write_read();
        wr = 1'b1; waddr = 5'd2; wdata = 32'd7;
        tick();
        waddr = 5'd4; wdata = 32'd20;
        tick();
        wr = 1'b0; ra1 = 5'd2; ra2 = 5'd4;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd7 || a_rd2 !== 32'd20) begin
            n_err++; $display("FAIL write_read_a: got %0d/%0d required 7/20", a_rd1, a_rd2);
        end
        n_cmp++;
        if (b_rd1 !== 32'd7 || b_rd2 !== 32'd20) begin
            n_err++; $display("FAIL write_read_b: got %0d/%0d required 7/20", b_rd1, b_rd2);
        end
        wr = 1'b1; waddr = 5'd0; wdata = 32'd3; ra1 = 5'd0; ra2 = 5'd0;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd0) begin n_err++; $display("FAIL zero_reg_bypass: got %0d required 0", a_rd1); end
        tick();
        wr = 1'b0;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd0 || a_drop !== 1'b0) begin
            n_err++; $display("FAIL zero_reg_write: got rd=%0d drop=%b required 0/0", a_rd1, a_drop);
        end
    endtask

    task automatic test_bypass();
        wr = 1'b1; waddr = 5'd31; wdata = 32'd78; ra1 = 5'd31; ra2 = 5'd31;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd78 || a_rd2 !== 32'd78) begin
            n_err++; $display("FAIL bypass_on: got %0d/%0d required 78/78", a_rd1, a_rd2);
        end
        n_cmp++;
        if (b_rd1 !== 32'd0 || b_rd2 !== 32'd0) begin
            n_err++; $display("FAIL bypass_off_old: got %0d/%0d required 0/0", b_rd1, b_rd2);
        end
        tick();
        wr = 1'b0;
        #1;
        n_cmp++;
        if (b_rd1 !== 32'd78) begin n_err++; $display("FAIL bypass_off_next: got %0d required 78", b_rd1); end
    endtask

    task automatic test_small_config();
        c_wr = 1'b1; c_waddr = 3'd0; c_wdata = 16'hBEEF; c_ra1 = 3'd0; c_ra2 = 3'd5;
        #1;
        n_cmp++;
        if (c_rd1 !== 16'hBEEF) begin n_err++; $display("FAIL c_bypass_reg0: got %h required beef", c_rd1); end
        tick();
        c_wr = 1'b0; c_ra2 = 3'd0;
        #1;
        n_cmp++;
        if (c_rd1 !== 16'hBEEF || c_rd2 !== 16'hBEEF) begin
            n_err++; $display("FAIL c_reg0_store: got %h/%h required beef/beef", c_rd1, c_rd2);
        end
    endtask

    task automatic test_drop_during_sweep();
        int pulses = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (3) tick();
        wr = 1'b1; waddr = 5'd25; wdata = 32'd6;
        tick();
        wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (a_drop) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses !== 1) begin n_err++; $display("FAIL drop_pulse_count: got %0d required 1", pulses); end
        wait_idle();
        ra1 = 5'd25;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd0) begin n_err++; $display("FAIL dropped_write_lost: got %0d required 0", a_rd1); end
    endtask

    task automatic test_clear_restart();
        int cnt = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (10) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!a_busy) break;
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt !== 32) begin n_err++; $display("FAIL clear_restart_len: got %0d required 32", cnt); end
        wr = 1'b1; waddr = 5'd5; wdata = 32'd99;
        tick();
        clr = 1'b1; wdata = 32'd55;
        tick();
        clr = 1'b0; wr = 1'b0;
        #1;
        n_cmp++;
        if (a_busy !== 1'b1 || a_drop !== 1'b1) begin
            n_err++; $display("FAIL clear_wins: got busy=%b drop=%b required 1/1", a_busy, a_drop);
        end
        wait_idle();
        ra1 = 5'd5;
        #1;
        n_cmp++;
        if (a_rd1 !== 32'd0) begin n_err++; $display("FAIL clear_wipes: got %0d required 0", a_rd1); end
    endtask

    task automatic test_random();
        logic [31:0] e;
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 149) == 0);
            wr    = ($urandom_range(0, 1) == 1);
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            ra1   = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
            ra2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            c_rst   = ($urandom_range(0, 299) != 0);
            c_clr   = ($urandom_range(0, 99) == 0);
            c_wr    = ($urandom_range(0, 1) == 1);
            c_waddr = 3'($urandom_range(0, 7));
            c_wdata = 16'($urandom);
            c_ra1   = ($urandom_range(0, 2) == 0) ? c_waddr : 3'($urandom_range(0, 7));
            c_ra2   = 3'($urandom_range(0, 7));
            #1;
            e = exp_rd(0, 1'b1, 1'b1, rst_n, clr, wr, int'(waddr), wdata, int'(ra1));
            n_cmp++;
            if (a_rd1 !== e) begin n_err++; $display("FAIL rand_a_rd1 @%0d: got %h required %h", i, a_rd1, e); end
            e = exp_rd(0, 1'b1, 1'b1, rst_n, clr, wr, int'(waddr), wdata, int'(ra2));
            n_cmp++;
            if (a_rd2 !== e) begin n_err++; $display("FAIL rand_a_rd2 @%0d: got %h required %h", i, a_rd2, e); end
            e = exp_rd(0, 1'b0, 1'b1, rst_n, clr, wr, int'(waddr), wdata, int'(ra1));
            n_cmp++;
            if (b_rd1 !== e) begin n_err++; $display("FAIL rand_b_rd1 @%0d: got %h required %h", i, b_rd1, e); end
            n_cmp++;
            if (a_busy !== m_busy[0] || a_drop !== m_drop[0]) begin
                n_err++; $display("FAIL rand_a_ctrl @%0d: got busy=%b drop=%b required %b/%b",
                                  i, a_busy, a_drop, m_busy[0], m_drop[0]);
            end
            e = exp_rd(1, 1'b1, 1'b0, c_rst, c_clr, c_wr, int'(c_waddr), {16'h0, c_wdata}, int'(c_ra1));
            n_cmp++;
            if (c_rd1 !== e[15:0]) begin n_err++; $display("FAIL rand_c_rd1 @%0d: got %h required %h", i, c_rd1, e[15:0]); end
            e = exp_rd(1, 1'b1, 1'b0, c_rst, c_clr, c_wr, int'(c_waddr), {16'h0, c_wdata}, int'(c_ra2));
            n_cmp++;
            if (c_rd2 !== e[15:0]) begin n_err++; $display("FAIL rand_c_rd2 @%0d: got %h required %h", i, c_rd2, e[15:0]); end
            n_cmp++;
            if (c_busy !== m_busy[1] || c_drop !== m_drop[1]) begin
                n_err++; $display("FAIL rand_c_ctrl @%0d: got busy=%b drop=%b required %b/%b",
                                  i, c_busy, c_drop, m_busy[1], m_drop[1]);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; waddr = '0; wdata = '0; ra1 = '0; ra2 = '0;
        c_rst = 1'b0; c_clr = 1'b0; c_wr = 1'b0; c_waddr = '0; c_wdata = '0; c_ra1 = '0; c_ra2 = '0;
        m_busy[0] = 1'b1; m_busy[1] = 1'b1;
        m_left[0] = 32;   m_left[1] = 8;
        m_drop[0] = 1'b0; m_drop[1] = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_small_config();
        test_drop_during_sweep();
        test_clear_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
